fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Memory-side initiator for the CPU's unified byte memory.
- Holds the PC and issues read addresses to the memory block.
- Captures the 3-byte read word and decodes 6502 instruction length (1/2/3).
- Presents each instruction to decode with a valid/ready handshake; advances the PC; handles redirects (jump/branch) and arbitrates single-byte store requests from execute onto the same memory port.

Parameters:
- MEM_ADDR_SIZE, nes_cpu_pkg value, width of memory byte address and PC.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- mem_addr_o  out  MEM_ADDR_SIZE  memory byte address (read or write).
- mem_we_o  out  1  memory write enable.
- mem_data_o  out  8  store byte to memory.
- mem_data_i  in  24  read word {byte[a+2], byte[a+1], byte[a]}, valid one cycle after address.
- redirect_valid_i  in  1  load new PC, flush.
- redirect_pc_i  in  MEM_ADDR_SIZE  redirect target.
- st_valid_i  in  1  store request.
- st_addr_i  in  MEM_ADDR_SIZE  store address.
- st_data_i  in  8  store byte.
- st_ready_o  out  1  store accepted this cycle.
- instr_valid_o  out  1  instruction available.
- instr_ready_i  in  1  decode accepts.
- instr_o  out  24  raw bytes, opcode in [7:0].
- instr_len_o  out  2  length 1..3.
- instr_pc_o  out  MEM_ADDR_SIZE  address of opcode.

Behaviour:
- Reset values: pc=RESET_PC, state=S_ISSUE, instr_valid_o=0, instr_o=0, instr_len_o=0, instr_pc_o=0, mem_we_o=0, mem_data_o=0, st_ready_o=0, mem_addr_o=RESET_PC.
- Memory contract: synchronous read with 1-cycle latency; a write is committed at the clock edge where mem_we_o=1.
- S_ISSUE:
  - st_ready_o=1.
  - If st_valid_i: drive mem_addr_o=st_addr_i, mem_we_o=1, mem_data_o=st_data_i, and stay in S_ISSUE. Stores have priority over fetch; continuous stores starve fetch, which is the intended behaviour.
  - Otherwise: mem_addr_o=pc, mem_we_o=0, next state S_RESP.
- S_RESP: on the edge, instr_o<=mem_data_i, instr_pc_o<=pc, instr_len_o<=len(mem_data_i[7:0]), instr_valid_o<=1, next state S_VALID.
- S_VALID:
  - Hold all instr_* stable while instr_ready_i=0.
  - On handshake: pc<=pc+len (modulo 2**MEM_ADDR_SIZE), instr_valid_o<=0, next state S_ISSUE.
  - st_ready_o=0 outside S_ISSUE.
- Length decode on opcode op:
  - 1 if op[3:0] is 8 or A, or op is 00, 40 or 60.
  - Else 3 if op[3:0] is C, D, E or F, or (op[3:0]==9 and op[4]==1), or op==20.
  - Else 2.
- Redirect (any state, highest priority):
  - pc<=redirect_pc_i, instr_valid_o<=0, state<=S_ISSUE.
  - Any in-flight S_RESP data is discarded.
  - A store presented in S_ISSUE in the same cycle is not accepted (st_ready_o=0).
  - A handshake coinciding with redirect counts as consumed, and the PC takes the redirect target.
- Wrap: pc+len and the read of pc+1/pc+2 wrap modulo 2**MEM_ADDR_SIZE.
- Baseline latency: address issue to instr_valid_o is 2 cycles; throughput is 1 instruction per 3 cycles with ready held high.
- Reset mid-operation returns all state to reset values immediately.

Optional Feature:
- Macro FETCH_PREFETCH_EN.
- When defined, in S_VALID the block drives mem_addr_o=pc+instr_len_o (mem_we_o=0).
- On handshake it goes directly to S_RESP, giving 1 instruction per 2 cycles.
- Stores are still accepted only in S_ISSUE, which is entered when decode is stalled: if instr_ready_i=0 and st_valid_i=1, the prefetch is abandoned and the store is served first.
- When undefined, mem_addr_o holds pc in S_VALID, and behaviour is as above.

Test Plan:
- Reset with RESET_PC=0; memory {09,FF,FF,29,FF,FF} -> instr_o=FFFF09, len=2, instr_pc_o=0; after handshake next instr_pc_o=2, instr_o=FF29FF (opcode FF, len 3).
- Opcodes 0A, 0D, 19, 11, 20, 60 at successive PCs -> lengths 1, 3, 3, 2, 3, 1, with PC advancing accordingly.
- Hold instr_ready_i=0 for 5 cycles -> instr_* stable, instr_valid_o=1, no new read issued.
- Redirect to 0x0010 during S_RESP -> the captured word is discarded; the next instr_pc_o is 0x0010.
- st_valid_i with st_addr_i=0x0005, st_data_i=AB in S_ISSUE -> mem_we_o=1 for that cycle, st_ready_o=1; a later fetch of 0x0005 returns opcode AB.
- PC at 2**MEM_ADDR_SIZE-2 with len 3 -> next PC is 1 (wrap).

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch and memory-port owner for the 6502 core.
//
// Keeps the PC, reads a 3-byte window {byte[a+2], byte[a+1], byte[a]} from
// the unified byte memory, decodes the 6502 instruction length from the
// opcode and hands each instruction to decode over a valid/ready handshake.
// Single-byte stores from execute share the same memory port. Stores are
// only accepted while the fetcher is idle in S_ISSUE, and they take priority
// over a new fetch there.
//
// Optional build macro: FETCH_PREFETCH_EN
//   When defined, the next sequential read is issued while the current
//   instruction waits in S_VALID. On a handshake the fetcher goes straight
//   to S_RESP, so throughput becomes 1 instruction per 2 cycles.
//
// Parameters
//   MEM_ADDR_SIZE  byte address / PC width (mirrors the nes_cpu_pkg value)
//   RESET_PC       PC loaded on reset
//
// Ports
//   clk_i, rstn_i               clock, asynchronous active-low reset
//   mem_addr_o/we_o/data_o      memory request (read or byte write)
//   mem_data_i                  read word, valid one cycle after the address
//   redirect_valid_i/pc_i       load a new PC and flush (highest priority)
//   st_valid_i/addr_i/data_i    store request from execute
//   st_ready_o                  store accepted this cycle
//   instr_valid_o/ready_i       handshake with decode
//   instr_o/len_o/pc_o          raw bytes (opcode in [7:0]), length 1..3, opcode PC
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_ISSUE | port idle: serve a store, or issue a read at pc
// S_RESP  | read data arrives this cycle; it is captured on the edge
// S_VALID | instruction presented to decode, waiting for instr_ready_i

module fetch_unit #(
    parameter int                       MEM_ADDR_SIZE = 16,
    parameter logic [MEM_ADDR_SIZE-1:0] RESET_PC      = '0
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
    output logic                     mem_we_o,
    output logic [7:0]               mem_data_o,
    input  logic [23:0]              mem_data_i,
    input  logic                     redirect_valid_i,
    input  logic [MEM_ADDR_SIZE-1:0] redirect_pc_i,
    input  logic                     st_valid_i,
    input  logic [MEM_ADDR_SIZE-1:0] st_addr_i,
    input  logic [7:0]               st_data_i,
    output logic                     st_ready_o,
    output logic                     instr_valid_o,
    input  logic                     instr_ready_i,
    output logic [23:0]              instr_o,
    output logic [1:0]               instr_len_o,
    output logic [MEM_ADDR_SIZE-1:0] instr_pc_o
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_RESP  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [MEM_ADDR_SIZE-1:0] pc;
    logic [MEM_ADDR_SIZE-1:0] pc_seq;
    logic                     handshake;
    logic                     st_fire;

    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [3:0] lo;
        lo = op[3:0];
        if (lo == 4'h8 || lo == 4'hA || op == 8'h00 || op == 8'h40 || op == 8'h60)
            return 2'd1;
        else if (lo >= 4'hC || (lo == 4'h9 && op[4]) || op == 8'h20)
            return 2'd3;
        else
            return 2'd2;
    endfunction

    // Address of the instruction following the one held in S_VALID; the
    // adder width gives the required modulo-2**MEM_ADDR_SIZE wrap.
    assign pc_seq    = pc + {{(MEM_ADDR_SIZE-2){1'b0}}, instr_len_o};
    assign handshake = (state == S_VALID) && instr_ready_i;
    // rstn_i is included so the port is quiet while reset is held.
    assign st_fire   = (state == S_ISSUE) && st_valid_i && !redirect_valid_i && rstn_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= S_ISSUE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid_i) begin
            state_nxt = S_ISSUE;
        end else begin
            case (state)
                S_ISSUE: state_nxt = st_valid_i ? S_ISSUE : S_RESP;
                S_RESP:  state_nxt = S_VALID;
                S_VALID: begin
`ifdef FETCH_PREFETCH_EN
                    if (instr_ready_i)   state_nxt = S_RESP;
                    else if (st_valid_i) state_nxt = S_ISSUE;
`else
                    if (instr_ready_i)   state_nxt = S_ISSUE;
`endif
                end
                default: state_nxt = S_ISSUE;
            endcase
        end
    end

    always_comb begin
        st_ready_o = (state == S_ISSUE) && !redirect_valid_i && rstn_i;
        mem_we_o   = st_fire;
        mem_data_o = st_fire ? st_data_i : 8'h00;
        mem_addr_o = st_fire ? st_addr_i : pc;
`ifdef FETCH_PREFETCH_EN
        if (state == S_VALID) mem_addr_o = pc_seq;
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc            <= RESET_PC;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            instr_len_o   <= '0;
            instr_pc_o    <= '0;
        end else if (redirect_valid_i) begin
            // Also covers a handshake in the same cycle: the instruction is
            // consumed, but the PC follows the redirect target.
            pc            <= redirect_pc_i;
            instr_valid_o <= 1'b0;
        end else if (state == S_RESP) begin
            instr_o       <= mem_data_i;
            instr_pc_o    <= pc;
            instr_len_o   <= decode_len(mem_data_i[7:0]);
            instr_valid_o <= 1'b1;
        end else if (handshake) begin
            pc            <= pc_seq;
            instr_valid_o <= 1'b0;
`ifdef FETCH_PREFETCH_EN
        end else if (state == S_VALID && st_valid_i) begin
            // Decode is stalled and a store is waiting: drop the instruction
            // and refetch it from pc after the store, which may have changed it.
            instr_valid_o <= 1'b0;
`endif
        end
    end

endmodule
